// File: rtl/traffic_pkg.sv
// Shared constants and helpers for the traffic light request front end.
package traffic_pkg;

  localparam int unsigned SYNC_STAGES = 2;

  // Width needed to hold a debounce count of 0..d.
  function automatic int unsigned cnt_width(input int unsigned d);
    return $clog2(d + 1);
  endfunction

endpackage

// File: rtl/traffic_request_conditioner_debounce_channel.sv
// One sensor channel: synchroniser, debounce filter, press detect, request latch
// and overrun flag.
module debounce_channel
  import traffic_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  input  logic ack,
  output logic req,
  output logic level,
  output logic overrun
);

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt;
  logic                   sample_c;
  logic                   settle_c;
  logic                   press_c;

  assign sample_c = sync_q[SYNC_STAGES-1];
  // Filtered level flips only after a full run of differing samples.
  assign settle_c = (sample_c != level) && (cnt == CNT_LAST);
  assign press_c  = settle_c && sample_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      cnt     <= '0;
      level   <= 1'b0;
      req     <= 1'b0;
      overrun <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};

      if (sample_c == level) begin
        cnt <= '0;
      end else if (settle_c) begin
        cnt   <= '0;
        level <= sample_c;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end

      // A fresh press outranks a same-cycle ack so no event is dropped.
      if (press_c) begin
        req <= 1'b1;
      end else if (ack) begin
        req <= 1'b0;
      end

      overrun <= press_c && req;
    end
  end

endmodule

// File: rtl/traffic_request_conditioner.sv
// Conditions two raw sensor lines into latched, acknowledged service requests.
module traffic_request_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic sensor_a_raw,
  input  logic sensor_b_raw,
  input  logic ack_a,
  input  logic ack_b,
  output logic req_a,
  output logic req_b,
  output logic level_a,
  output logic level_b,
  output logic overrun_a,
  output logic overrun_b
);

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_chan_a (
    .clk    (clk),
    .rst    (rst),
    .raw    (sensor_a_raw),
    .ack    (ack_a),
    .req    (req_a),
    .level  (level_a),
    .overrun(overrun_a)
  );

  debounce_channel #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_chan_b (
    .clk    (clk),
    .rst    (rst),
    .raw    (sensor_b_raw),
    .ack    (ack_b),
    .req    (req_b),
    .level  (level_b),
    .overrun(overrun_b)
  );

endmodule

// File: tb/tb_traffic_request_conditioner.sv
// Directed bench for traffic_request_conditioner with DEBOUNCE_CYCLES = 4.
module tb_traffic_request_conditioner;

  logic clk;
  logic rst;
  logic sensor_a_raw;
  logic sensor_b_raw;
  logic ack_a;
  logic ack_b;
  logic req_a;
  logic req_b;
  logic level_a;
  logic level_b;
  logic overrun_a;
  logic overrun_b;

  int n_tests = 0;
  int n_fail  = 0;

  traffic_request_conditioner #(
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sensor_a_raw(sensor_a_raw),
    .sensor_b_raw(sensor_b_raw),
    .ack_a       (ack_a),
    .ack_b       (ack_b),
    .req_a       (req_a),
    .req_b       (req_b),
    .level_a     (level_a),
    .level_b     (level_b),
    .overrun_a   (overrun_a),
    .overrun_b   (overrun_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  // Advance one rising edge, then settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] all_outs();
    return {2'b00, req_a, req_b, level_a, level_b, overrun_a, overrun_b};
  endfunction

  initial begin
    logic seen;
    rst = 1'b1;
    sensor_a_raw = 1'b0;
    sensor_b_raw = 1'b0;
    ack_a = 1'b0;
    ack_b = 1'b0;

    // Reset held with noisy raw lines
    for (int i = 0; i < 3; i++) begin
      sensor_a_raw = ~sensor_a_raw;
      sensor_b_raw = (i == 1);
      step();
      check($sformatf("reset_outs_%0d", i), all_outs(), 8'h00);
    end
    rst = 1'b0;
    sensor_a_raw = 1'b0;
    sensor_b_raw = 1'b0;
    step();
    check("post_reset_outs", all_outs(), 8'h00);
    for (int i = 0; i < 4; i++) step();

    // Clean press on A: visible exactly after the 6th edge
    sensor_a_raw = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      check($sformatf("press_a_early_%0d", i), {6'd0, req_a, level_a}, 8'h00);
    end
    step();
    check("press_a_req_level", {6'd0, req_a, level_a}, 8'h03);
    check("press_a_b_quiet", {6'd0, req_b, level_b}, 8'h00);
    seen = 1'b0;
    for (int i = 0; i < 14; i++) begin
      step();
      seen = seen | overrun_a | overrun_b | req_b;
    end
    check("press_a_no_overrun", {7'd0, seen}, 8'h00);
    check("press_a_held", {6'd0, req_a, level_a}, 8'h03);

    // Ack clears A after one edge; ack on idle B is ignored
    ack_a = 1'b1;
    step();
    ack_a = 1'b0;
    check("ack_a_drop", {6'd0, req_a, level_a}, 8'h01);
    ack_b = 1'b1;
    step();
    ack_b = 1'b0;
    check("ack_b_idle", {6'd0, req_b, level_b}, 8'h00);

    // Release A, then bounce pattern must never produce a press
    sensor_a_raw = 1'b0;
    for (int i = 0; i < 8; i++) step();
    check("release_a", {6'd0, req_a, level_a}, 8'h00);
    seen = 1'b0;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 8; i++) begin
        sensor_a_raw = (i != 3) && (i != 7);
        step();
        seen = seen | level_a | req_a;
      end
    end
    sensor_a_raw = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      seen = seen | level_a | req_a;
    end
    check("bounce_reject", {7'd0, seen}, 8'h00);

    // Press again, release without ack: request stays latched
    sensor_a_raw = 1'b1;
    for (int i = 0; i < 6; i++) step();
    check("repress_a", {6'd0, req_a, level_a}, 8'h03);
    sensor_a_raw = 1'b0;
    for (int i = 0; i < 8; i++) step();
    check("release_keeps_req", {6'd0, req_a, level_a}, 8'h02);

    // New press coinciding with ack: press wins, overrun pulses once
    sensor_a_raw = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("pre_overrun", {6'd0, level_a, overrun_a}, 8'h00);
    ack_a = 1'b1;
    step();
    ack_a = 1'b0;
    check("press_ack_req", {5'd0, req_a, level_a, overrun_a}, 8'h07);
    step();
    check("overrun_one_cycle", {6'd0, req_a, overrun_a}, 8'h02);
    ack_a = 1'b1;
    step();
    ack_a = 1'b0;
    check("ack_after_overrun", {7'd0, req_a}, 8'h00);
    sensor_a_raw = 1'b0;
    for (int i = 0; i < 8; i++) step();

    // Reset mid-debounce on B discards the partial count
    sensor_b_raw = 1'b1;
    for (int i = 0; i < 3; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_reset_outs", all_outs(), 8'h00);
    for (int i = 1; i <= 5; i++) begin
      step();
      check($sformatf("mid_reset_early_%0d", i), {6'd0, req_b, level_b}, 8'h00);
    end
    step();
    check("mid_reset_req_b", {6'd0, req_b, level_b}, 8'h03);
    check("mid_reset_a_quiet", {6'd0, req_a, level_a}, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
